// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity transmit/receive path.
// The frame length constant is also used by the matching deserializer.
package even_parity_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } state_e;

  localparam int unsigned DataW    = 3;
  localparam int unsigned FrameLen = DataW + 1;

  function automatic int unsigned frame_len(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/even_parity_serial_tx_if.sv
// Parallel-in handshake plus serial-out signals of the even-parity transmitter.
// The master side drives words in; the slave side is the transmitter itself.
interface even_parity_serial_tx_if
  import even_parity_pkg::*;
#(
  parameter int unsigned DATA_W = DataW
);

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              err_inj;
  logic              sdo;
  logic              sdo_valid;
  logic              frame_start;
  logic              pb;
  logic              busy;

  modport master (
    output din, din_valid, err_inj,
    input  din_ready, sdo, sdo_valid, frame_start, pb, busy
  );

  modport slave (
    input  din, din_valid, err_inj,
    output din_ready, sdo, sdo_valid, frame_start, pb, busy
  );

endinterface

// File: rtl/even_parity_gen.sv
// Combinational even-parity generator: XOR reduction of the data word.
// Counterpart of the even-parity checker; reusable on the receive side.
module even_parity_gen
  import even_parity_pkg::*;
#(
  parameter int unsigned DATA_W = DataW
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = ^data;

endmodule

// File: rtl/even_parity_serial_tx.sv
// Serial even-parity frame transmitter: data MSB-first, then the parity bit.
// Outputs are decoded from registered state only; din_ready depends on state alone.
module even_parity_serial_tx
  import even_parity_pkg::*;
#(
  parameter int unsigned DATA_W = DataW
) (
  input logic                     clk,
  input logic                     rst_n,
  even_parity_serial_tx_if.slave  bus
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pb_q, pb_d;
  logic              first_q, first_d;
  logic              parity;
  logic              ready;
  logic              accept;

  even_parity_gen #(
    .DATA_W (DATA_W)
  ) u_gen (
    .data   (bus.din),
    .parity (parity)
  );

  assign ready  = (state_q != StShift);
  assign accept = bus.din_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      pb_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      pb_q    <= pb_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pb_d    = pb_q;
    first_d = 1'b0;
    unique case (state_q)
      StIdle, StParity: begin
        if (accept) begin
          shift_d = bus.din;
          pb_d    = parity ^ bus.err_inj;
          cnt_d   = CntW'(DATA_W - 1);
          first_d = 1'b1;
          state_d = StShift;
        end else if (state_q == StParity) begin
          state_d = StIdle;
        end
      end
      StShift: begin
        shift_d = shift_q << 1;
        if (cnt_q == '0) begin
          state_d = StParity;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.sdo         = 1'b0;
    bus.sdo_valid   = 1'b0;
    bus.busy        = 1'b0;
    bus.din_ready   = ready;
    bus.frame_start = first_q;
    bus.pb          = pb_q;
    unique case (state_q)
      StShift: begin
        bus.sdo       = shift_q[DATA_W-1];
        bus.sdo_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      StParity: begin
        bus.sdo       = pb_q;
        bus.sdo_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Directed bench for even_parity_serial_tx with DATA_W=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_even_parity_serial_tx;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  even_parity_serial_tx_if #(.DATA_W(3)) bus ();

  even_parity_serial_tx #(
    .DATA_W (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.err_inj   = 1'b0;
    #1;
    vectors++;
    if ({bus.sdo, bus.sdo_valid, bus.frame_start, bus.pb, bus.busy, bus.din_ready} !== 6'b000001)
    begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 000001",
               {bus.sdo, bus.sdo_valid, bus.frame_start, bus.pb, bus.busy, bus.din_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single(input logic [2:0] word, input logic inj, input logic [3:0] exp_bits,
                             input logic exp_pb, input logic exp_cp, input string name);
    logic [3:0] got;
    bus.din       = word;
    bus.din_valid = 1'b1;
    bus.err_inj   = inj;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.sdo !== exp_bits[3-i] || bus.sdo_valid !== 1'b1 || bus.busy !== 1'b1 ||
          bus.frame_start !== (i == 0)) begin
        miscompares++;
        $display("FAIL %s_bit%0d: got sdo=%b v=%b busy=%b fs=%b expected sdo=%b v=1 busy=1 fs=%b",
                 name, i, bus.sdo, bus.sdo_valid, bus.busy, bus.frame_start, exp_bits[3-i],
                 (i == 0));
      end
      got[3-i] = bus.sdo;
      if (i == 0) begin
        bus.din_valid = 1'b0;
        bus.err_inj   = 1'b0;
      end
    end
    @(negedge clk);
    vectors++;
    if (bus.sdo_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pb !== exp_pb) begin
      miscompares++;
      $display("FAIL %s_idle: got v=%b busy=%b pb=%b expected v=0 busy=0 pb=%b",
               name, bus.sdo_valid, bus.busy, bus.pb, exp_pb);
    end
    vectors++;
    if ((^got) !== exp_cp) begin
      miscompares++;
      $display("FAIL %s_checker: got cp=%b expected %b", name, ^got, exp_cp);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bits = 8'b0011_1100;
    bus.din       = 3'b001;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.sdo !== exp_bits[7-i] || bus.sdo_valid !== 1'b1 ||
          bus.frame_start !== (i == 0 || i == 4)) begin
        miscompares++;
        $display("FAIL b2b_bit%0d: got sdo=%b v=%b fs=%b expected sdo=%b v=1 fs=%b",
                 i, bus.sdo, bus.sdo_valid, bus.frame_start, exp_bits[7-i], (i == 0 || i == 4));
      end
      if (i == 3) begin
        vectors++;
        if (bus.din_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready_parity: got %b expected 1", bus.din_ready);
        end
        bus.din       = 3'b110;
        bus.din_valid = 1'b1;
      end
      if (i == 0 || i == 4) bus.din_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (bus.sdo_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got v=%b expected 0", bus.sdo_valid);
    end
  endtask

  task automatic test_hold_while_busy();
    logic [7:0] exp_bits = 8'b1010_0101;
    bus.din       = 3'b101;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.sdo !== exp_bits[7-i] || bus.din_ready !== (i % 4 == 3)) begin
        miscompares++;
        $display("FAIL hold_bit%0d: got sdo=%b ready=%b expected sdo=%b ready=%b",
                 i, bus.sdo, bus.din_ready, exp_bits[7-i], (i % 4 == 3));
      end
      if (i == 0) bus.din = 3'b010;
      if (i == 4) bus.din_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (bus.sdo_valid !== 1'b0 || bus.pb !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_idle: got v=%b pb=%b expected v=0 pb=1", bus.sdo_valid, bus.pb);
    end
  endtask

  task automatic test_reset_mid_frame();
    bus.din       = 3'b100;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1 || bus.sdo_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_before: got busy=%b v=%b expected 1 1", bus.busy, bus.sdo_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.sdo, bus.sdo_valid, bus.busy, bus.pb, bus.din_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL rstmid_async: got %b expected 00001",
               {bus.sdo, bus.sdo_valid, bus.busy, bus.pb, bus.din_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.sdo_valid !== 1'b0 || bus.sdo !== 1'b0 || bus.din_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rstmid_after%0d: got v=%b sdo=%b ready=%b expected 0 0 1",
                 i, bus.sdo_valid, bus.sdo, bus.din_ready);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single(3'b101, 1'b0, 4'b1010, 1'b0, 1'b0, "single");
    test_single(3'b111, 1'b0, 4'b1111, 1'b1, 1'b0, "odd");
    test_back_to_back();
    test_single(3'b000, 1'b1, 4'b0001, 1'b1, 1'b1, "errinj");
    test_hold_while_busy();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/even_parity_serial_tx.md
# even_parity_serial_tx

Serial even-parity frame transmitter, the send side of the even-parity checking path. It accepts a parallel data word through a valid/ready handshake and computes the even parity bit. It then shifts out the data bits MSB-first, followed by the parity bit, on a single serial line with a qualifying valid strobe. A receiver that deserializes a frame into data bits i[DATA_W-1:0] plus pb and feeds them to the even-parity checker must see checker output 0 for every frame sent without error injection.

## Interface
- DATA_W, 3, data bits per frame (≥1); a frame is DATA_W+1 serial bits.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  DATA_W  parallel data word, sampled on acceptance.
- din_valid  input  1  din is presented.
- din_ready  output  1  block can accept a word this cycle.
- err_inj  input  1  sampled with din on acceptance; when 1, that frame's parity bit is inverted.
- sdo  output  1  serial data out.
- sdo_valid  output  1  sdo carries a frame bit this cycle.
- frame_start  output  1  high during the first bit (MSB) of each frame.
- pb  output  1  parity bit of the frame in flight; held until the next acceptance.
- busy  output  1  a frame is being shifted out.

## Operation
- States: IDLE, SHIFT, PARITY.
- Acceptance is `din_valid && din_ready`. On acceptance:
  - shift register ← din
  - pb ← ^din ^ err_inj
  - bit counter ← DATA_W-1
  - next state SHIFT
- IDLE: din_ready=1; sdo_valid=0; sdo=0. If a word is accepted, go to SHIFT; otherwise stay in IDLE.
- SHIFT:
  - sdo = shift register MSB; sdo_valid=1; din_ready=0.
  - Each cycle the register shifts left by one and the counter decrements.
  - When the counter is 0, go to PARITY.
- PARITY:
  - sdo = pb; sdo_valid=1; din_ready=1.
  - Acceptance in this cycle goes straight to SHIFT with the new word. This gives back-to-back frames with no idle gap.
  - With no acceptance, go to IDLE.
- din_valid while busy in SHIFT is ignored. The word is not consumed, and the upstream side must hold it until din_ready.
- Even parity rule: XOR of all DATA_W data bits and pb = 0 when err_inj=0, and = 1 when err_inj=1.
- DATA_W=1: SHIFT lasts exactly one cycle.

## Timing
- Reset values, applied immediately on rst_n low regardless of clk:
  - state=IDLE; sdo=0; sdo_valid=0; frame_start=0; pb=0; busy=0; din_ready=1.
  - Internal registers are cleared.
- Reset mid-frame aborts the frame. No remaining bits are emitted after reset release.
- Latency: a word accepted at edge k drives its MSB on sdo in cycle k+1, with frame_start=1 in that cycle only.
- Frame duration is DATA_W+1 cycles, with sdo_valid continuously high throughout.
- Sustained throughput is one word per DATA_W+1 cycles when din_valid is held high.
- busy = 1 in SHIFT and PARITY.
- All outputs are registered or decoded from registered state only; there is no combinational path from din or din_valid to any output except din_ready. din_ready itself is state-decoded and independent of din_valid.

## Structure
- Shared package `even_parity_pkg` holds:
  - the state enum (IDLE, SHIFT, PARITY)
  - the default DATA_W
  - the frame length constant DATA_W+1, which the matching receiver/deserializer also uses
- One sub-module is natural: `even_parity_gen`, a combinational XOR reduction of DATA_W bits producing the parity bit. It is the generator counterpart of the checker and is reusable by the receiver.

## Test plan
- Single frame: din=3'b101, err_inj=0 → sdo 1,0,1,0 over 4 cycles starting the cycle after acceptance; pb=0; frame_start only on the first bit; then idle with sdo_valid=0.
- Odd-weight word: din=3'b111 → sdo 1,1,1,1; pb=1. The deserialized frame into the checker gives cp=0.
- Back-to-back: din=3'b001, then 3'b110 accepted in the PARITY cycle → sdo 0,0,1,1,1,1,0,0 with sdo_valid high for 8 consecutive cycles and frame_start on cycles 1 and 5.
- Error injection: din=3'b000 with err_inj=1 → sdo 0,0,0,1; the checker reports cp=1.
- Hold while busy: din_valid held high with 3'b010 during a frame → din_ready=0 in SHIFT; the word is accepted only in the PARITY cycle and sent unmodified as 0,1,0,1.
- Reset mid-frame: assert rst_n=0 during the second bit of 3'b100 → sdo, sdo_valid and busy drop to 0 at once without waiting for clk. After release the block sits in IDLE with din_ready=1 and emits no residual bits.
